branch_predict_resolver: RTL and testbench
==========================================

// Module: branch_predict_resolver
// PURPOSE
//  Parametrised branch unit that resolves MIPS conditional branches and learns from them.
//  - Resolves the condition in the execute stage (same 3-bit branch code set as the current resolver).
//  - Provides a fetch-stage taken prediction from a table of 2-bit saturating counters.
//  - Raises a registered mispredict pulse so the pipeline can flush and redirect.
//  - Keeps saturating branch/mispredict statistics readable by the SOC.
// PARAMETERS
//  INDEX_BITS    6      BHT index width; table holds 2**INDEX_BITS counters
//  CNT_WIDTH     16     width of the statistics counters
//  COUNTER_INIT  2'b01  reset value of every BHT counter (weakly not-taken)
// PORTS
//  clk               in   1          rising-edge clock
//  rst               in   1          asynchronous reset, active-high
//  fetch_pc          in   32         PC of the instruction being fetched
//  predict_taken     out  1          combinational prediction for fetch_pc
//  resolve_valid     in   1          execute stage holds a decoded instruction this cycle
//  resolve_pc        in   32         PC of the instruction in execute
//  branch            in   3          0 none,1 beq,2 bne,3 bgez,4 bgtz,5 blez,6 bltz,7 reserved
//  zero              in   1          ALU result == 0
//  sign              in   1          ALU result[31]
//  resolve_predicted in   1          prediction carried down the pipe with this instruction
//  branch_taken      out  1          combinational resolved outcome
//  mispredict        out  1          registered 1-cycle pulse: outcome != prediction
//  mispredict_taken  out  1          registered; branch_taken of the mispredicted branch
//  stats_clear       in   1          synchronous clear of the statistics counters
//  branch_count      out  CNT_WIDTH  resolved conditional branches, saturating
//  mispredict_count  out  CNT_WIDTH  mispredictions, saturating
// BEHAVIOUR
//  Condition (combinational):
//   - taken = resolve_valid & f(branch, zero, sign):
//     1 zero | 2 ~zero | 3 ~sign | 4 ~sign&~zero | 5 sign|zero | 6 sign.
//   - Codes 0 and 7 are never taken. No latch; every path assigns.
//  Conditional branch: cond = resolve_valid & branch in 1..6.
//  Index:
//   - fetch index  = fetch_pc[INDEX_BITS+1:2]
//   - update index = resolve_pc[INDEX_BITS+1:2]
//  Prediction:
//   - predict_taken = bht[fetch index][1].
//   - Read is asynchronous, no bypass: a same-cycle update to the same index is NOT reflected.
//  BHT update (posedge, when cond):
//   - taken: counter+1, saturating at 3.
//   - not taken: counter-1, saturating at 0.
//   - No update when cond=0.
//  Mispredict:
//   - mispredict <= cond & (branch_taken != resolve_predicted).
//   - mispredict_taken <= branch_taken when that mispredict is set, else holds its value.
//   - Latency 1 cycle; cleared the next cycle unless the new cycle mispredicts again.
//  Statistics (posedge):
//   - stats_clear=1 -> both counters 0; clear wins over a simultaneous count.
//   - Otherwise branch_count +1 on cond; mispredict_count +1 on cond&mismatch.
//   - Both stop at all-ones and never wrap.
//  Reset (async, any time, including mid-stream):
//   - All BHT entries = COUNTER_INIT.
//   - mispredict = 0, mispredict_taken = 0, both counters = 0.
//   - After rst deasserts, the first edge behaves normally.
//  Widths: PC bits outside the index field are ignored (aliasing accepted, no tags).
// TESTING
//  1. rst pulse mid-run -> predict_taken=0 for every index; counters 0; mispredict 0 within the same cycle.
//  2. beq zero=1 at pc 0x40, predicted 0, twice:
//     - bht[16] goes 01->10->11; predict_taken for 0x40 = 1 after the first update.
//     - mispredict pulses once per branch, mispredict_taken=1.
//  3. All 8 codes x 4 zero/sign combos -> branch_taken matches the table; codes 0/7 give 0 and no count change.
//  4. Saturation:
//     - Five not-taken bne at one index -> counter stays 00.
//     - With CNT_WIDTH=4, 20 branches -> branch_count=15.
//  5. Update and fetch hit the same index in one cycle -> predict_taken shows the old value; the new value appears next cycle.
//  6. stats_clear together with a mispredicting branch -> counters 0 next cycle, mispredict still pulses, BHT still updates.

Source files
------------

// File: rtl/branch_predict_resolver.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_resolver
// Purpose  : Resolves MIPS conditional branches in the execute stage, predicts
//            fetch-stage direction from a table of 2-bit saturating counters,
//            flags mispredictions one cycle later and keeps saturating
//            branch / mispredict statistics.
// Ports    : clk, rst (async, active-high)
//            fetch_pc -> predict_taken            (fetch-side lookup)
//            resolve_valid, resolve_pc, branch,
//            zero, sign, resolve_predicted -> branch_taken (execute side)
//            mispredict, mispredict_taken         (registered flush request)
//            stats_clear -> branch_count, mispredict_count
// Revision : 1.0  initial release
// ============================================================================
module branch_predict_resolver #(
  parameter int         INDEX_BITS   = 6,
  parameter int         CNT_WIDTH    = 16,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          fetch_pc,
  output logic                 predict_taken,
  input  logic                 resolve_valid,
  input  logic [31:0]          resolve_pc,
  input  logic [2:0]           branch,
  input  logic                 zero,
  input  logic                 sign,
  input  logic                 resolve_predicted,
  output logic                 branch_taken,
  output logic                 mispredict,
  output logic                 mispredict_taken,
  input  logic                 stats_clear,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int                 c_ENTRIES = 1 << INDEX_BITS;
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [INDEX_BITS-1:0] w_fetch_idx;
  logic [INDEX_BITS-1:0] w_update_idx;
  logic                  w_cond_true;
  logic                  w_cond;
  logic                  w_mismatch;
  logic [c_ENTRIES-1:0]  w_pred_bits;

  assign w_fetch_idx  = fetch_pc[INDEX_BITS+1:2];
  assign w_update_idx = resolve_pc[INDEX_BITS+1:2];

  // PC bits outside the index field are deliberately ignored (no tags).
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = &{1'b0, fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                              resolve_pc[31:INDEX_BITS+2], resolve_pc[1:0]};

  // Branch condition evaluation; codes 0 and 7 fall into the default.
  always_comb begin
    w_cond_true = 1'b0;
    case (branch)
      3'd1:    w_cond_true = zero;            // beq
      3'd2:    w_cond_true = ~zero;           // bne
      3'd3:    w_cond_true = ~sign;           // bgez
      3'd4:    w_cond_true = ~sign & ~zero;   // bgtz
      3'd5:    w_cond_true = sign | zero;     // blez
      3'd6:    w_cond_true = sign;            // bltz
      default: w_cond_true = 1'b0;
    endcase
  end

  assign branch_taken = resolve_valid & w_cond_true;
  assign w_cond       = resolve_valid & (branch != 3'd0) & (branch != 3'd7);
  assign w_mismatch   = branch_taken != resolve_predicted;

  // One 2-bit saturating counter per entry. Each entry owns its register so
  // the prediction read below sees only the pre-edge value (no bypass).
  generate
    for (genvar g = 0; g < c_ENTRIES; g++) begin : g_bht
      logic [1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= COUNTER_INIT;
        end else if (w_cond && (w_update_idx == INDEX_BITS'(g))) begin
          if (branch_taken) begin
            if (r_cnt != 2'b11) r_cnt <= r_cnt + 2'd1;
          end else begin
            if (r_cnt != 2'b00) r_cnt <= r_cnt - 2'd1;
          end
        end
      end

      assign w_pred_bits[g] = r_cnt[1];
    end
  endgenerate

  assign predict_taken = w_pred_bits[w_fetch_idx];

  // Flush request: one-cycle pulse; the direction is kept until the next
  // misprediction so the redirect logic can read it late if needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict       <= 1'b0;
      mispredict_taken <= 1'b0;
    end else begin
      mispredict <= w_cond & w_mismatch;
      if (w_cond && w_mismatch) mispredict_taken <= branch_taken;
    end
  end

  // Statistics: clear has priority over counting; both saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (stats_clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (w_cond && (branch_count != c_CNT_MAX))
        branch_count <= branch_count + 1'b1;
      if (w_cond && w_mismatch && (mispredict_count != c_CNT_MAX))
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_resolver
// Purpose  : Directed self-checking bench for branch_predict_resolver
//            (INDEX_BITS=6, CNT_WIDTH=4 so counter saturation is reachable).
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predict_resolver;

  localparam int c_CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     fetch_pc;
  logic            predict_taken;
  logic            resolve_valid;
  logic [31:0]     resolve_pc;
  logic [2:0]      branch;
  logic            zero;
  logic            sign;
  logic            resolve_predicted;
  logic            branch_taken;
  logic            mispredict;
  logic            mispredict_taken;
  logic            stats_clear;
  logic [c_CW-1:0] branch_count;
  logic [c_CW-1:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_predict_resolver #(
    .INDEX_BITS  (6),
    .CNT_WIDTH   (c_CW),
    .COUNTER_INIT(2'b01)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .predict_taken    (predict_taken),
    .resolve_valid    (resolve_valid),
    .resolve_pc       (resolve_pc),
    .branch           (branch),
    .zero             (zero),
    .sign             (sign),
    .resolve_predicted(resolve_predicted),
    .branch_taken     (branch_taken),
    .mispredict       (mispredict),
    .mispredict_taken (mispredict_taken),
    .stats_clear      (stats_clear),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] code,
                       input logic z, input logic s, input logic pred);
    resolve_valid     = v;
    resolve_pc        = pc;
    branch            = code;
    zero              = z;
    sign              = s;
    resolve_predicted = pred;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_stats();
    idle();
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
  endtask

  // Expected taken per code, indexed by {zero,sign}.
  logic [3:0] taken_tab [8];
  logic [3:0] tab_row;
  int         n_taken;

  initial begin
    taken_tab[0] = 4'b0000; taken_tab[1] = 4'b1100;
    taken_tab[2] = 4'b0011; taken_tab[3] = 4'b0101;
    taken_tab[4] = 4'b0001; taken_tab[5] = 4'b1110;
    taken_tab[6] = 4'b1010; taken_tab[7] = 4'b0000;

    rst = 1'b1; fetch_pc = 32'h0; stats_clear = 1'b0;
    idle();
    repeat (2) tick();
    rst = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i) << 2;
      #1 chk("reset_predict", predict_taken, 0);
    end
    chk("reset_misp", mispredict, 0);
    chk("reset_misp_taken", mispredict_taken, 0);
    chk("reset_bcnt", branch_count, 0);
    chk("reset_mcnt", mispredict_count, 0);

    // beq taken at 0x40, predicted not-taken, twice; fetch hits same index
    fetch_pc = 32'h40;
    drive(1'b1, 32'h40, 3'd1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("beq_taken", branch_taken, 1);
    chk("same_idx_old_pred", predict_taken, 0);
    chk("misp_not_yet", mispredict, 0);
    tick();
    chk("pred_after_1st", predict_taken, 1);
    chk("misp_1st", mispredict, 1);
    chk("misp_taken_1st", mispredict_taken, 1);
    chk("bcnt_1st", branch_count, 1);
    chk("mcnt_1st", mispredict_count, 1);
    tick();
    chk("misp_2nd", mispredict, 1);
    chk("bcnt_2nd", branch_count, 2);
    chk("mcnt_2nd", mispredict_count, 2);
    // Correctly predicted: counter already at 3, no mispredict
    drive(1'b1, 32'h40, 3'd1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("misp_correct", mispredict, 0);
    chk("misp_taken_hold", mispredict_taken, 1);
    chk("bcnt_3rd", branch_count, 3);
    chk("mcnt_3rd", mispredict_count, 2);
    // Upper saturation: 11 stays 11, then two not-taken -> 10 -> 01
    drive(1'b1, 32'h40, 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pred_from_sat3", predict_taken, 1);
    chk("misp_nt", mispredict, 1);
    chk("misp_taken_nt", mispredict_taken, 0);
    tick();
    chk("pred_down_to_01", predict_taken, 0);
    idle();
    #1 chk("invalid_not_taken", branch_taken, 0);
    drive(1'b0, 32'h40, 3'd1, 1'b1, 1'b0, 1'b0);
    #1 chk("valid0_beq", branch_taken, 0);
    tick();
    chk("valid0_no_misp", mispredict, 0);
    chk("valid0_no_count", branch_count, 5);

    // Full condition table at index 0 (pc 0x100), predicted not-taken
    for (int c = 0; c < 8; c++) begin
      clear_stats();
      tab_row = taken_tab[c];
      n_taken = 0;
      for (int zs = 0; zs < 4; zs++) begin
        drive(1'b1, 32'h100, 3'(c), zs[1], zs[0], 1'b0);
        #1 chk($sformatf("cond_c%0d_zs%0d", c, zs), branch_taken, tab_row[zs]);
        if (tab_row[zs]) n_taken++;
        tick();
      end
      idle();
      chk($sformatf("bcnt_code%0d", c), branch_count, (c == 0 || c == 7) ? 0 : 4);
      chk($sformatf("mcnt_code%0d", c), mispredict_count, n_taken);
    end

    // Lower saturation: five not-taken bne at 0x80, then taken twice
    fetch_pc = 32'h80;
    repeat (5) begin
      drive(1'b1, 32'h80, 3'd2, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h80, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sat0_then_01", predict_taken, 0);
    tick();
    chk("sat0_then_10", predict_taken, 1);

    // Counter saturation: 20 mispredicted taken branches -> 15 / 15
    clear_stats();
    repeat (20) begin
      drive(1'b1, 32'h200, 3'd1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("bcnt_sat", branch_count, 15);
    chk("mcnt_sat", mispredict_count, 15);

    // stats_clear with a mispredicting branch at 0xC0
    fetch_pc = 32'hC0;
    drive(1'b1, 32'hC0, 3'd1, 1'b1, 1'b0, 1'b0);
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    chk("clr_bcnt", branch_count, 0);
    chk("clr_mcnt", mispredict_count, 0);
    chk("clr_misp", mispredict, 1);
    chk("clr_bht_upd", predict_taken, 1);
    tick();
    idle();
    chk("post_clr_bcnt", branch_count, 1);
    chk("post_clr_misp", mispredict, 1);

    // Mid-cycle asynchronous reset while mispredict is high
    #2 rst = 1'b1;
    #1;
    chk("midrst_misp", mispredict, 0);
    chk("midrst_misp_taken", mispredict_taken, 0);
    chk("midrst_bcnt", branch_count, 0);
    chk("midrst_mcnt", mispredict_count, 0);
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i) << 2;
      #0.05 chk("midrst_predict", predict_taken, 0);
    end
    tick();
    rst = 1'b0;
    // First edge after reset behaves normally
    fetch_pc = 32'h40;
    drive(1'b1, 32'h40, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("post_rst_pred", predict_taken, 1);
    chk("post_rst_misp", mispredict, 1);
    chk("post_rst_bcnt", branch_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
